// File: rtl/core_dcache_pkg.sv
// Shared constants and FSM encodings for the direct-mapped write-through data cache.
package core_dcache_pkg;

  localparam int WORD_W      = 32;
  localparam int OFFSET_BITS = 2;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOOKUP = 3'd1;
  localparam state_t ST_RD_AR  = 3'd2;
  localparam state_t ST_RD_R   = 3'd3;
  localparam state_t ST_WR_REQ = 3'd4;
  localparam state_t ST_WR_B   = 3'd5;

endpackage

// File: rtl/core_dcache_if.sv
// Core-side and memory-side bus bundles for core_dcache.
interface dcache_core_if #(parameter int ADDR_WIDTH = 32);
  import core_dcache_pkg::*;

  logic [ADDR_WIDTH-1:0] core_ARADDR;
  logic                  core_ARVALID;
  logic [WORD_W-1:0]     core_RDATA;
  logic                  core_RVALID;
  logic [ADDR_WIDTH-1:0] core_AWADDR;
  logic                  core_AWVALID;
  logic [WORD_W-1:0]     core_WDATA;
  logic                  core_BVALID;

  modport master (
    output core_ARADDR, core_ARVALID, core_AWADDR, core_AWVALID, core_WDATA,
    input  core_RDATA, core_RVALID, core_BVALID
  );
  modport slave (
    input  core_ARADDR, core_ARVALID, core_AWADDR, core_AWVALID, core_WDATA,
    output core_RDATA, core_RVALID, core_BVALID
  );
endinterface

interface dcache_mem_if #(parameter int ADDR_WIDTH = 32);
  import core_dcache_pkg::*;

  logic [ADDR_WIDTH-1:0] mem_araddr;
  logic                  mem_arvalid;
  logic                  mem_arready;
  logic [WORD_W-1:0]     mem_rdata;
  logic                  mem_rvalid;
  logic [ADDR_WIDTH-1:0] mem_awaddr;
  logic                  mem_awvalid;
  logic                  mem_awready;
  logic [WORD_W-1:0]     mem_wdata;
  logic                  mem_wvalid;
  logic                  mem_wready;
  logic                  mem_bvalid;

  modport master (
    output mem_araddr, mem_arvalid, mem_awaddr, mem_awvalid, mem_wdata, mem_wvalid,
    input  mem_arready, mem_rdata, mem_rvalid, mem_awready, mem_wready, mem_bvalid
  );
  modport slave (
    input  mem_araddr, mem_arvalid, mem_awaddr, mem_awvalid, mem_wdata, mem_wvalid,
    output mem_arready, mem_rdata, mem_rvalid, mem_awready, mem_wready, mem_bvalid
  );
endinterface

// File: rtl/core_dcache_array.sv
// Tag + data storage: one synchronous read port (1-cycle latency), one write port.
module dcache_array #(
  parameter int INDEX_BITS = 8,
  parameter int TAG_BITS   = 22,
  parameter int WORD_W     = 32
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [WORD_W-1:0]     rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [WORD_W-1:0]     wr_data
);
  logic [TAG_BITS-1:0] tag_mem  [2**INDEX_BITS];
  logic [WORD_W-1:0]   data_mem [2**INDEX_BITS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
    if (rd_en) begin
      rd_tag  <= tag_mem[rd_idx];
      rd_data <= data_mem[rd_idx];
    end
  end
endmodule

// File: rtl/core_dcache.sv
// Direct-mapped, write-through, no-write-allocate cache with one-word lines.
//   state     | meaning
//   IDLE      | accept request / pending read, array read issued
//   LOOKUP    | tag compare; hit responds, miss goes to memory
//   RD_AR     | memory read address outstanding
//   RD_R      | waiting for memory read data, then fill
//   WR_REQ    | memory AW/W outstanding; hit line updated on entry
//   WR_B      | waiting for memory write response
module core_dcache
  import core_dcache_pkg::*;
#(
  parameter int INDEX_BITS = 8,
  parameter int ADDR_WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  input logic          flush,
  dcache_core_if.slave core,
  dcache_mem_if.master mem
);
  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
  localparam int LINES    = 2**INDEX_BITS;
  localparam int IDX_HI   = INDEX_BITS + OFFSET_BITS - 1;

  state_t                            state;
  logic [LINES-1:0]                  valid;
  logic [ADDR_WIDTH-1:OFFSET_BITS]   addr_q;
  logic [ADDR_WIDTH-1:OFFSET_BITS]   pend_addr;
  logic                              pend_v;
  logic [WORD_W-1:0]                 wdata_q;
  logic                              wr_entry;

  logic                  rd_en, wr_en, hit;
  logic [INDEX_BITS-1:0] rd_idx, idx_q;
  logic [TAG_BITS-1:0]   rd_tag, tag_q;
  logic [WORD_W-1:0]     rd_data, wr_data;
  logic                  unused_lsbs;

  assign idx_q       = addr_q[IDX_HI:OFFSET_BITS];
  assign tag_q       = addr_q[ADDR_WIDTH-1:IDX_HI+1];
  assign hit         = valid[idx_q] && (rd_tag == tag_q);
  assign unused_lsbs = ^{core.core_ARADDR[OFFSET_BITS-1:0], core.core_AWADDR[OFFSET_BITS-1:0]};

  // The array is read in IDLE with the index of whatever request will be taken next.
  always_comb begin
    rd_en = (state == ST_IDLE);
    if (pend_v)
      rd_idx = pend_addr[IDX_HI:OFFSET_BITS];
    else if (core.core_AWVALID)
      rd_idx = core.core_AWADDR[IDX_HI:OFFSET_BITS];
    else
      rd_idx = core.core_ARADDR[IDX_HI:OFFSET_BITS];
    wr_en   = 1'b0;
    wr_data = wdata_q;
    if (state == ST_RD_R && mem.mem_rvalid) begin
      wr_en   = 1'b1;
      wr_data = mem.mem_rdata;
    end else if (state == ST_WR_REQ && wr_entry && hit) begin
      wr_en = 1'b1;
    end
  end

  dcache_array #(.INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS), .WORD_W(WORD_W)) u_array (
    .clk(clk), .rd_en(rd_en), .rd_idx(rd_idx), .rd_tag(rd_tag), .rd_data(rd_data),
    .wr_en(wr_en), .wr_idx(idx_q), .wr_tag(tag_q), .wr_data(wr_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= ST_IDLE;
      valid            <= '0;
      addr_q           <= '0;
      pend_addr        <= '0;
      pend_v           <= 1'b0;
      wdata_q          <= '0;
      wr_entry         <= 1'b0;
      core.core_RDATA  <= '0;
      core.core_RVALID <= 1'b0;
      core.core_BVALID <= 1'b0;
      mem.mem_araddr   <= '0;
      mem.mem_arvalid  <= 1'b0;
      mem.mem_awaddr   <= '0;
      mem.mem_awvalid  <= 1'b0;
      mem.mem_wdata    <= '0;
      mem.mem_wvalid   <= 1'b0;
    end else begin
      core.core_RVALID <= 1'b0;
      core.core_BVALID <= 1'b0;
      wr_entry         <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (flush) valid <= '0;
          if (pend_v) begin
            addr_q <= pend_addr;
            pend_v <= 1'b0;
            state  <= ST_LOOKUP;
          end else if (core.core_AWVALID) begin
            addr_q          <= core.core_AWADDR[ADDR_WIDTH-1:OFFSET_BITS];
            wdata_q         <= core.core_WDATA;
            wr_entry        <= 1'b1;
            mem.mem_awaddr  <= {core.core_AWADDR[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            mem.mem_awvalid <= 1'b1;
            mem.mem_wdata   <= core.core_WDATA;
            mem.mem_wvalid  <= 1'b1;
            state           <= ST_WR_REQ;
            if (core.core_ARVALID) begin
              pend_v    <= 1'b1;
              pend_addr <= core.core_ARADDR[ADDR_WIDTH-1:OFFSET_BITS];
            end
          end else if (core.core_ARVALID) begin
            addr_q <= core.core_ARADDR[ADDR_WIDTH-1:OFFSET_BITS];
            state  <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (hit) begin
            core.core_RDATA  <= rd_data;
            core.core_RVALID <= 1'b1;
            state            <= ST_IDLE;
          end else begin
            mem.mem_araddr  <= {addr_q, {OFFSET_BITS{1'b0}}};
            mem.mem_arvalid <= 1'b1;
            state           <= ST_RD_AR;
          end
        end
        ST_RD_AR: begin
          if (mem.mem_arready) begin
            mem.mem_arvalid <= 1'b0;
            state           <= ST_RD_R;
          end
        end
        ST_RD_R: begin
          if (mem.mem_rvalid) begin
            valid[idx_q]     <= 1'b1;
            core.core_RDATA  <= mem.mem_rdata;
            core.core_RVALID <= 1'b1;
            state            <= ST_IDLE;
          end
        end
        ST_WR_REQ: begin
          if (mem.mem_awready) mem.mem_awvalid <= 1'b0;
          if (mem.mem_wready)  mem.mem_wvalid  <= 1'b0;
          if ((!mem.mem_awvalid || mem.mem_awready) && (!mem.mem_wvalid || mem.mem_wready))
            state <= ST_WR_B;
        end
        ST_WR_B: begin
          if (mem.mem_bvalid) begin
            core.core_BVALID <= 1'b1;
            state            <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_core_dcache.sv
// Scoreboard bench for core_dcache with a behavioural memory on the master port.
`timescale 1ns/1ps
module tb_core_dcache;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  dcache_core_if c();
  dcache_mem_if  m();

  core_dcache #(.INDEX_BITS(8), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .core(c.slave), .mem(m.master)
  );

  typedef struct { logic is_wr; logic [31:0] data; } exp_t;
  exp_t sb[$];

  int total = 0, bad = 0;
  int cyc = 0;
  int ar_count = 0, wr_count = 0, r_seen = 0, b_seen = 0;
  int req_cyc = 0, last_r_cyc = 0;
  int ar_delay = 0, r_delay = 1, aw_delay = 0, w_delay = 0, b_delay = 1;
  logic [31:0] last_araddr = '0, last_awaddr = '0;
  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] golden    [logic [31:0]];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction
  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    return golden.exists(align(a)) ? golden[align(a)] : dflt(align(a));
  endfunction
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_model.exists(align(a)) ? mem_model[align(a)] : dflt(align(a));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic take(input logic is_wr, input logic [31:0] d, input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_unexpected"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({tag, "_order"}, {31'd0, is_wr}, {31'd0, e.is_wr});
    if (!is_wr) check(tag, d, e.data);
  endtask

  // Response monitor
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (c.core_RVALID) begin
        r_seen++;
        last_r_cyc = cyc;
        take(1'b0, c.core_RDATA, "rdata");
      end
      if (c.core_BVALID) begin
        b_seen++;
        take(1'b1, 32'd0, "bresp");
      end
    end
  end

  // Memory read channel
  initial begin : mem_rd_chan
    logic [31:0] a;
    m.mem_arready = 1'b0; m.mem_rvalid = 1'b0; m.mem_rdata = '0;
    forever begin
      tick();
      if (m.mem_arvalid) begin
        a = m.mem_araddr;
        last_araddr = a;
        repeat (ar_delay) tick();
        m.mem_arready = 1'b1;
        tick();
        m.mem_arready = 1'b0;
        ar_count++;
        repeat (r_delay) tick();
        m.mem_rdata = mem_rd(a);
        m.mem_rvalid = 1'b1;
        tick();
        m.mem_rvalid = 1'b0;
      end
    end
  end

  // Memory write channel
  initial begin : mem_wr_chan
    logic [31:0] a, d;
    m.mem_awready = 1'b0; m.mem_wready = 1'b0; m.mem_bvalid = 1'b0;
    forever begin
      tick();
      if (m.mem_awvalid && m.mem_wvalid) begin
        a = m.mem_awaddr;
        d = m.mem_wdata;
        last_awaddr = a;
        fork
          begin repeat (aw_delay) tick(); m.mem_awready = 1'b1; tick(); m.mem_awready = 1'b0; end
          begin repeat (w_delay)  tick(); m.mem_wready  = 1'b1; tick(); m.mem_wready  = 1'b0; end
        join
        mem_model[a] = d;
        wr_count++;
        repeat (b_delay) tick();
        m.mem_bvalid = 1'b1;
        tick();
        m.mem_bvalid = 1'b0;
      end
    end
  end

  task automatic rd(input logic [31:0] a);
    exp_t e;
    e.is_wr = 1'b0; e.data = gold_rd(a);
    sb.push_back(e);
    c.core_ARADDR = a; c.core_ARVALID = 1'b1; req_cyc = cyc;
    tick();
    c.core_ARVALID = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.is_wr = 1'b1; e.data = d;
    sb.push_back(e);
    golden[align(a)] = d;
    c.core_AWADDR = a; c.core_WDATA = d; c.core_AWVALID = 1'b1;
    tick();
    c.core_AWVALID = 1'b0;
  endtask

  task automatic rw_same(input logic [31:0] wa, input logic [31:0] d, input logic [31:0] ra);
    exp_t e;
    e.is_wr = 1'b1; e.data = d;
    sb.push_back(e);
    golden[align(wa)] = d;
    e.is_wr = 1'b0; e.data = gold_rd(ra);
    sb.push_back(e);
    c.core_AWADDR = wa; c.core_WDATA = d; c.core_AWVALID = 1'b1;
    c.core_ARADDR = ra; c.core_ARVALID = 1'b1;
    tick();
    c.core_AWVALID = 1'b0; c.core_ARVALID = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
    repeat (3) tick();
  endtask

  initial begin : main
    int n, nb, nr;
    logic [31:0] ra, wa, wd;
    c.core_ARADDR = '0; c.core_ARVALID = 1'b0;
    c.core_AWADDR = '0; c.core_AWVALID = 1'b0; c.core_WDATA = '0;
    repeat (3) tick();
    check("rst_rvalid",  {31'd0, c.core_RVALID}, 32'd0);
    check("rst_bvalid",  {31'd0, c.core_BVALID}, 32'd0);
    check("rst_rdata",   c.core_RDATA, 32'd0);
    check("rst_arvalid", {31'd0, m.mem_arvalid}, 32'd0);
    check("rst_awvalid", {31'd0, m.mem_awvalid}, 32'd0);
    check("rst_wvalid",  {31'd0, m.mem_wvalid}, 32'd0);
    check("rst_araddr",  m.mem_araddr, 32'd0);
    rst = 1'b1;
    tick();

    mem_model[32'h100] = 32'hDEADBEEF;
    golden[32'h100]    = 32'hDEADBEEF;
    n = ar_count; rd(32'h100); drain();
    check("cold_ar", ar_count - n, 32'd1);
    check("cold_araddr", last_araddr, 32'h100);

    n = ar_count; rd(32'h100); drain();
    check("hit_ar", ar_count - n, 32'd0);
    check("hit_lat", last_r_cyc - req_cyc, 32'd2);

    n = wr_count; wr(32'h100, 32'h12345678); drain();
    check("wr_mem_count", wr_count - n, 32'd1);
    check("wr_awaddr", last_awaddr, 32'h100);
    check("wr_mem_data", mem_rd(32'h100), 32'h12345678);
    n = ar_count; rd(32'h101); drain();
    check("wr_hit_ar", ar_count - n, 32'd0);

    wr(32'h203, 32'hCAFE0001); drain();
    check("wmiss_awaddr", last_awaddr, 32'h200);
    n = ar_count; rd(32'h200); drain();
    check("no_alloc_ar", ar_count - n, 32'd1);
    check("miss_araddr", last_araddr, 32'h200);

    n = ar_count; rd(32'h500); drain();
    check("alias_ar", ar_count - n, 32'd1);
    n = ar_count; rd(32'h100); drain();
    check("evict_ar", ar_count - n, 32'd1);

    n = ar_count; rw_same(32'h100, 32'hA1B2C3D4, 32'h100); drain();
    check("same_hit_ar", ar_count - n, 32'd0);
    rw_same(32'h600, 32'h00000011, 32'h500); drain();

    flush = 1'b1; tick(); flush = 1'b0;
    n = ar_count; rd(32'h100); drain();
    check("flush_ar", ar_count - n, 32'd1);
    flush = 1'b1; n = ar_count; rd(32'h100); flush = 1'b0; drain();
    check("flush_req_ar", ar_count - n, 32'd1);

    aw_delay = 3; w_delay = 0;
    nb = b_seen; wr(32'h100, 32'h0F0F0F0F); drain(); repeat (5) tick();
    check("aw_late_single_b", b_seen - nb, 32'd1);
    aw_delay = 0; w_delay = 2;
    nb = b_seen; wr(32'h104, 32'hF0F0F0F0); drain(); repeat (5) tick();
    check("w_late_single_b", b_seen - nb, 32'd1);
    w_delay = 0;

    r_delay = 8;
    n = ar_count;
    c.core_ARADDR = 32'h700; c.core_ARVALID = 1'b1; tick(); c.core_ARVALID = 1'b0;
    for (int i = 0; i < 50 && ar_count == n; i++) tick();
    check("rstmid_ar_seen", ar_count - n, 32'd1);
    tick();
    nr = r_seen;
    rst = 1'b0; tick(); tick();
    check("rstmid_arvalid", {31'd0, m.mem_arvalid}, 32'd0);
    check("rstmid_rvalid",  {31'd0, c.core_RVALID}, 32'd0);
    rst = 1'b1;
    repeat (15) tick();
    check("rstmid_no_resp", r_seen - nr, 32'd0);
    r_delay = 1;
    n = ar_count; rd(32'h100); drain();
    check("rstmid_cleared_ar", ar_count - n, 32'd1);

    for (int k = 0; k < 24; k++) begin
      ar_delay = $urandom_range(0, 3); r_delay = $urandom_range(0, 3);
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
      b_delay  = $urandom_range(0, 3);
      ra = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      wa = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 2);
      wd = $urandom;
      case ($urandom_range(0, 2))
        0:       rd(ra);
        1:       wr(wa, wd);
        default: rw_same(wa, wd, ra);
      endcase
      drain();
    end
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end
endmodule
